// File: rtl/pixel_bus_arbiter_if.sv
// pixel_bus_arbiter_if: groups the requester handshakes and the bus master signals of the
// pixel bus arbiter.
//   master modport : arbiter side (drives grants, pops, strobes and the bus request side)
//   slave modport  : environment side (requesters, output buffer and bus master interface)
// Parameters ADDR_W / DATA_W must match those of the arbiter instance.
interface pixel_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // Pixel-fetch read path
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_grant;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    // Output-buffer flush write path
    logic              wr_req;
    logic              wr_urgent;
    logic [ADDR_W-1:0] wr_addr;
    logic [3:0]        wr_len;
    logic [DATA_W-1:0] wr_data;
    logic              wr_grant;
    logic              wr_pop;
    logic              wr_done;
    // Bus master interface
    logic              bus_start;
    logic              bus_write;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_done;
    logic              busy;

    modport master (
        input  rd_req, rd_addr, wr_req, wr_urgent, wr_addr, wr_len, wr_data, bus_rdata, bus_done,
        output rd_grant, rd_data, rd_valid, wr_grant, wr_pop, wr_done,
        output bus_start, bus_write, bus_addr, bus_wdata, busy
    );

    modport slave (
        output rd_req, rd_addr, wr_req, wr_urgent, wr_addr, wr_len, wr_data, bus_rdata, bus_done,
        input  rd_grant, rd_data, rd_valid, wr_grant, wr_pop, wr_done,
        input  bus_start, bus_write, bus_addr, bus_wdata, busy
    );
endinterface

// File: rtl/pixel_bus_arbiter.sv
// pixel_bus_arbiter: shares one bus master port between single-word pixel reads and
// output-buffer write bursts of 1..WR_BURST words. Sequences arbitration, issue, completion
// wait and burst address stepping.
// Ports:
//   clk     : clock, rising edge
//   n_rst   : asynchronous active-low reset (abandons any transaction in flight)
//   arb_io  : pixel_bus_arbiter_if.master - requester handshakes and bus signals
// Optional feature: define ARB_STARVE_GUARD_EN to force a write grant after STARVE_LIMIT
// consecutive read grants with wr_req pending. Default build is pure fixed priority.
module pixel_bus_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned WR_BURST     = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    pixel_bus_arbiter_if.master arb_io
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_ISSUE = 3'd1;
    localparam logic [2:0] RD_WAIT  = 3'd2;
    localparam logic [2:0] WR_LOAD  = 3'd3;
    localparam logic [2:0] WR_ISSUE = 3'd4;
    localparam logic [2:0] WR_WAIT  = 3'd5;

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);
    localparam logic [3:0]        BURST_MAX = 4'(WR_BURST);

    if (WR_BURST < 1 || WR_BURST > 8 || STARVE_LIMIT < 1) begin : g_bad_params
        $error("pixel_bus_arbiter: WR_BURST must be 1..8 and STARVE_LIMIT at least 1");
    end

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [3:0]        beat_cnt_q, beat_cnt_d;
    logic [3:0]        len_q, len_d;
    logic              bus_write_q, bus_write_d;
    logic              rd_valid_q, rd_valid_d;
    logic              wr_done_q, wr_done_d;

    logic              rd_grant, wr_grant, wr_pop, bus_start;
    logic              wr_win, rd_win, wr_force;
    logic [3:0]        len_clamped;

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
    logic [StarveW-1:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!arb_io.wr_req || wr_grant) begin
            starve_cnt_d = '0;
        end else if (rd_grant && starve_cnt_q != StarveW'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) starve_cnt_q <= '0;
        else        starve_cnt_q <= starve_cnt_d;
    end

    assign wr_force = (starve_cnt_q == StarveW'(STARVE_LIMIT));
`else
    assign wr_force = 1'b0;
`endif

    // Zero-length requests still move one word; over-long ones are cut to the burst limit.
    always_comb begin
        if (arb_io.wr_len == 4'd0)          len_clamped = 4'd1;
        else if (arb_io.wr_len > BURST_MAX) len_clamped = BURST_MAX;
        else                                len_clamped = arb_io.wr_len;
    end

    assign wr_win = arb_io.wr_req && (arb_io.wr_urgent || !arb_io.rd_req || wr_force);
    assign rd_win = arb_io.rd_req && !wr_win;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_data_d   = rd_data_q;
        beat_cnt_d  = beat_cnt_q;
        len_d       = len_q;
        bus_write_d = bus_write_q;
        rd_valid_d  = 1'b0;
        wr_done_d   = 1'b0;
        rd_grant    = 1'b0;
        wr_grant    = 1'b0;
        wr_pop      = 1'b0;
        bus_start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_win) begin
                    wr_grant    = 1'b1;
                    addr_d      = arb_io.wr_addr;
                    beat_cnt_d  = 4'd0;
                    len_d       = len_clamped;
                    bus_write_d = 1'b1;
                    state_d     = WR_LOAD;
                end else if (rd_win) begin
                    rd_grant    = 1'b1;
                    addr_d      = arb_io.rd_addr;
                    bus_write_d = 1'b0;
                    state_d     = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                bus_start = 1'b1;
                state_d   = RD_WAIT;
            end
            RD_WAIT: begin
                if (arb_io.bus_done) begin
                    rd_data_d  = arb_io.bus_rdata;
                    rd_valid_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            WR_LOAD: begin
                wdata_d = arb_io.wr_data;
                wr_pop  = 1'b1;
                state_d = WR_ISSUE;
            end
            WR_ISSUE: begin
                bus_start = 1'b1;
                state_d   = WR_WAIT;
            end
            WR_WAIT: begin
                if (arb_io.bus_done) begin
                    if (beat_cnt_q == len_q - 4'd1) begin
                        wr_done_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        // Last beat leaves addr_q alone so bus_addr holds the final address.
                        addr_d     = addr_q + ADDR_STEP;
                        beat_cnt_d = beat_cnt_q + 4'd1;
                        state_d    = WR_LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_data_q   <= '0;
            beat_cnt_q  <= '0;
            len_q       <= '0;
            bus_write_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            wr_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_data_q   <= rd_data_d;
            beat_cnt_q  <= beat_cnt_d;
            len_q       <= len_d;
            bus_write_q <= bus_write_d;
            rd_valid_q  <= rd_valid_d;
            wr_done_q   <= wr_done_d;
        end
    end

    assign arb_io.rd_grant  = rd_grant;
    assign arb_io.wr_grant  = wr_grant;
    assign arb_io.wr_pop    = wr_pop;
    assign arb_io.bus_start = bus_start;
    assign arb_io.bus_write = bus_write_q;
    assign arb_io.bus_addr  = addr_q;
    assign arb_io.bus_wdata = wdata_q;
    assign arb_io.rd_data   = rd_data_q;
    assign arb_io.rd_valid  = rd_valid_q;
    assign arb_io.wr_done   = wr_done_q;
    assign arb_io.busy      = (state_q != IDLE);
endmodule

// File: doc/pixel_bus_arbiter.md
Name: pixel_bus_arbiter

Overview:
- Shares the single bus master port between two requesters. The pixel-fetch path issues single-word reads. The output-buffer flush path issues write bursts of 1..WR_BURST words.
- Sits between the Sobel main controller / output buffer and the bus master interface. It sequences every bus transaction: arbitration, issue, wait for completion, burst address stepping.

Parameters:
- ADDR_W, 32, bus address width.
- DATA_W, 32, bus data width. Burst address increment is DATA_W/8.
- WR_BURST, 4, maximum write burst length in words (power of two, 1..8).
- STARVE_LIMIT, 8, consecutive read grants allowed while wr_req is pending. Used only with ARB_STARVE_GUARD_EN.

Ports:
- clk  in  1  clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- rd_req  in  1  pixel read request. Held, with rd_addr stable, until rd_grant.
- rd_addr  in  ADDR_W  read address.
- rd_grant  out  1  one-cycle grant; rd_addr captured this cycle.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  one-cycle pulse; rd_data valid.
- wr_req  in  1  flush request. Held, with wr_addr/wr_len stable, until wr_grant.
- wr_urgent  in  1  output buffer full; forces write priority.
- wr_addr  in  ADDR_W  burst start address.
- wr_len  in  4  requested burst length in words.
- wr_data  in  DATA_W  head word of the first-word-fall-through output buffer.
- wr_grant  out  1  one-cycle grant.
- wr_pop  out  1  one-cycle pop of the output buffer head.
- wr_done  out  1  one-cycle pulse; burst complete.
- bus_start  out  1  one-cycle transfer start strobe.
- bus_write  out  1  1 = write, 0 = read. Held for the whole transfer.
- bus_addr  out  ADDR_W  transfer address. Held until bus_done.
- bus_wdata  out  DATA_W  write data. Held until bus_done.
- bus_rdata  in  DATA_W  read data, valid with bus_done.
- bus_done  in  1  transfer complete.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: state IDLE. All outputs, addr_q, wdata_q, beat_cnt, len_q and starve_cnt are 0. Reset mid-transfer abandons the transaction with no wr_done or rd_valid.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_LOAD, WR_ISSUE, WR_WAIT.
- IDLE arbitration, one decision per cycle:
  - Write wins if wr_req && (wr_urgent || !rd_req).
  - Otherwise read wins if rd_req.
  - Fixed priority: read over write unless wr_urgent.
- IDLE, read wins: rd_grant=1 combinationally, addr_q<=rd_addr, next state RD_ISSUE.
- IDLE, write wins:
  - wr_grant=1, addr_q<=wr_addr, beat_cnt<=0.
  - len_q<=wr_len, with wr_len=0 treated as 1 and wr_len>WR_BURST clamped to WR_BURST.
  - Next state WR_LOAD.
- RD_ISSUE: bus_start=1, bus_write=0, bus_addr=addr_q. Next state RD_WAIT.
- RD_WAIT: hold bus_addr. On bus_done: rd_data<=bus_rdata, rd_valid=1 in the following cycle, next state IDLE.
- Read latency: grant in cycle T, bus_start in T+1, rd_valid in cycle D+1 where D is the bus_done cycle.
- WR_LOAD: wdata_q<=wr_data, wr_pop=1. Next state WR_ISSUE.
- WR_ISSUE: bus_start=1, bus_write=1, bus_addr=addr_q, bus_wdata=wdata_q. Next state WR_WAIT.
- WR_WAIT: hold bus signals. On bus_done:
  - If beat_cnt==len_q-1: wr_done=1 in the following cycle, next state IDLE.
  - Else: addr_q+=DATA_W/8 (wraps modulo 2^ADDR_W), beat_cnt++, next state WR_LOAD.
- bus_done is ignored in IDLE, RD_ISSUE, WR_LOAD and WR_ISSUE.
- Requests are sampled only in IDLE. No back-to-back grant: at least one IDLE cycle separates transactions.
- wr_req or rd_req dropping mid-transaction has no effect; the burst completes with len_q beats.
- bus_write and bus_addr keep their last value in IDLE. bus_wdata keeps wdata_q.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- Defined:
  - starve_cnt increments on each rd_grant while wr_req=1.
  - It clears on wr_grant or whenever wr_req=0.
  - When starve_cnt==STARVE_LIMIT, IDLE grants write even if rd_req=1 and wr_urgent=0.
- Not defined: starve_cnt is absent; pure fixed priority as above.

Test Plan:
- Single read: rd_req, rd_addr=0x100, bus_done 3 cycles after bus_start, bus_rdata=0xA5A5 -> one rd_grant; bus_start at T+1 with bus_write=0, bus_addr=0x100; rd_valid with rd_data=0xA5A5 one cycle after bus_done.
- Write burst: wr_req, wr_addr=0x2000, wr_len=4, buffer words 1..4 -> bus_addr 0x2000/0x2004/0x2008/0x200C with bus_wdata 1..4; exactly 4 wr_pop; one wr_done after the 4th bus_done.
- Length clamping: wr_len=0 -> 1 beat; wr_len=9 with WR_BURST=4 -> 4 beats, 4 pops.
- Priority: rd_req and wr_req both high in the same IDLE cycle -> rd_grant. Repeat with wr_urgent=1 -> wr_grant, read served after the burst.
- Starvation guard (macro on, STARVE_LIMIT=8): rd_req held high continuously, wr_req held high -> 8 read grants, then wr_grant on the 9th arbitration. Macro off -> no wr_grant while rd_req stays high.
- Reset mid-burst: n_rst low during WR_WAIT of beat 2 -> all outputs 0 immediately, no wr_done; after release a new wr_req starts at beat 0 with the new wr_addr.
